// File: rtl/gbc_gamepak_sequencer.sv
// GBC cartridge bus sequencer: arbitrates CPU/DMA byte requests, runs setup/strobe/hold
// pak cycles and generates the cartridge reset pulse after system reset.
module gbc_gamepak_sequencer #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int RESET_HOLD    = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [15:0] CpuAddr,
    input  logic [7:0]  CpuWData,
    output logic        CpuAck,
    output logic [7:0]  CpuRData,
    input  logic        DmaReq,
    input  logic        DmaWrite,
    input  logic [15:0] DmaAddr,
    input  logic [7:0]  DmaWData,
    output logic        DmaAck,
    output logic [7:0]  DmaRData,
    output logic        PakClk,
    output logic [15:0] Address,
    output logic        Read,
    output logic        Write,
    output logic        CS,
    output logic [7:0]  DToPak,
    input  logic [7:0]  DFromPak,
    output logic        PakReset
);

    // state    | meaning
    // RST_HOLD | PakReset high, counting down after Reset release
    // IDLE     | strobes low, arbitrating requests
    // SETUP    | address/CS/Read stable before strobe
    // STROBE   | PakClk high (Write high for writes)
    // HOLD     | strobes low, address held, Ack pulses
    typedef enum logic [2:0] {RST_HOLD, IDLE, SETUP, STROBE, HOLD} state_t;

    localparam int M1   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAXC = (RESET_HOLD > M1) ? RESET_HOLD : M1;
    localparam int CW   = $clog2(MAXC + 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          is_write, is_write_d, is_dma, is_dma_d, last_dma, last_dma_d;
    logic [15:0]   address_d;
    logic [7:0]    dtopak_d, cpu_rdata_d, dma_rdata_d;
    logic          pakclk_d, read_d, write_d, cs_d, cpu_ack_d, dma_ack_d, pak_reset_d;

    logic          pick_dma, req_write, ext_ram, in_window;
    logic [15:0]   req_addr;
    logic [7:0]    req_wdata;

    // Alternate on contention so neither port can starve the other.
    assign pick_dma  = DmaReq && !(CpuReq && last_dma);
    assign req_write = pick_dma ? DmaWrite : CpuWrite;
    assign req_addr  = pick_dma ? DmaAddr  : CpuAddr;
    assign req_wdata = pick_dma ? DmaWData : CpuWData;
    assign ext_ram   = (req_addr[15:13] == 3'b101);
    assign in_window = !req_addr[15] || ext_ram;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= RST_HOLD;
            cnt      <= CW'(RESET_HOLD - 1);
            is_write <= 1'b0;
            is_dma   <= 1'b0;
            last_dma <= 1'b0;
            Address  <= 16'h0000;
            DToPak   <= 8'h00;
            CS       <= 1'b0;
            Read     <= 1'b0;
            Write    <= 1'b0;
            PakClk   <= 1'b0;
            PakReset <= 1'b1;
            CpuAck   <= 1'b0;
            DmaAck   <= 1'b0;
            CpuRData <= 8'hFF;
            DmaRData <= 8'hFF;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            is_write <= is_write_d;
            is_dma   <= is_dma_d;
            last_dma <= last_dma_d;
            Address  <= address_d;
            DToPak   <= dtopak_d;
            CS       <= cs_d;
            Read     <= read_d;
            Write    <= write_d;
            PakClk   <= pakclk_d;
            PakReset <= pak_reset_d;
            CpuAck   <= cpu_ack_d;
            DmaAck   <= dma_ack_d;
            CpuRData <= cpu_rdata_d;
            DmaRData <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        is_write_d  = is_write;
        is_dma_d    = is_dma;
        last_dma_d  = last_dma;
        address_d   = Address;
        dtopak_d    = DToPak;
        cs_d        = CS;
        read_d      = Read;
        write_d     = Write;
        pakclk_d    = PakClk;
        pak_reset_d = PakReset;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = CpuRData;
        dma_rdata_d = DmaRData;
        case (state)
            RST_HOLD: begin
                if (cnt == '0) begin
                    state_d     = IDLE;
                    pak_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            IDLE: begin
                if (CpuReq || DmaReq) begin
                    is_dma_d   = pick_dma;
                    last_dma_d = pick_dma;
                    is_write_d = req_write;
                    if (in_window) begin
                        state_d   = SETUP;
                        cnt_d     = CW'(SETUP_CYCLES - 1);
                        address_d = req_addr;
                        cs_d      = ext_ram;
                        read_d    = !req_write;
                        if (req_write)
                            dtopak_d = req_wdata;
                    end else begin
                        // No pak cycle: acknowledge straight away, reads float high.
                        state_d   = HOLD;
                        cpu_ack_d = !pick_dma;
                        dma_ack_d = pick_dma;
                        if (!req_write) begin
                            if (pick_dma)
                                dma_rdata_d = 8'hFF;
                            else
                                cpu_rdata_d = 8'hFF;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_d  = STROBE;
                    cnt_d    = CW'(STROBE_CYCLES - 1);
                    pakclk_d = 1'b1;
                    write_d  = is_write;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_d   = HOLD;
                    pakclk_d  = 1'b0;
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    cpu_ack_d = !is_dma;
                    dma_ack_d = is_dma;
                    if (!is_write) begin
                        if (is_dma)
                            dma_rdata_d = DFromPak;
                        else
                            cpu_rdata_d = DFromPak;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
            default: state_d = RST_HOLD;
        endcase
    end

endmodule

// File: tb/tb_gbc_gamepak_sequencer.sv
// Randomized self-checking bench for gbc_gamepak_sequencer against a per-cycle
// reference model derived from the access timing rules.
module tb_gbc_gamepak_sequencer;

    localparam int S  = 1;
    localparam int T  = 2;
    localparam int RH = 16;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        CpuReq = 1'b0, CpuWrite = 1'b0;
    logic [15:0] CpuAddr = 16'h0;
    logic [7:0]  CpuWData = 8'h0;
    logic        DmaReq = 1'b0, DmaWrite = 1'b0;
    logic [15:0] DmaAddr = 16'h0;
    logic [7:0]  DmaWData = 8'h0;
    logic [7:0]  DFromPak = 8'h0;
    logic        CpuAck, DmaAck, PakClk, Read, Write, CS, PakReset;
    logic [7:0]  CpuRData, DmaRData, DToPak;
    logic [15:0] Address;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_addr;
    logic [7:0]  m_dtopak, m_cpu_rdata, m_dma_rdata;
    bit          m_last_dma;

    gbc_gamepak_sequencer #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .RESET_HOLD(RH)) dut (
        .Clk(Clk), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuAck(CpuAck), .CpuRData(CpuRData),
        .DmaReq(DmaReq), .DmaWrite(DmaWrite), .DmaAddr(DmaAddr), .DmaWData(DmaWData),
        .DmaAck(DmaAck), .DmaRData(DmaRData),
        .PakClk(PakClk), .Address(Address), .Read(Read), .Write(Write), .CS(CS),
        .DToPak(DToPak), .DFromPak(DFromPak), .PakReset(PakReset)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic void model_reset();
        m_addr      = 16'h0000;
        m_dtopak    = 8'h00;
        m_cpu_rdata = 8'hFF;
        m_dma_rdata = 8'hFF;
        m_last_dma  = 1'b0;
    endfunction

    // One single-requester access from cycle 0 (IDLE, request raised now) through the
    // IDLE cycle following Ack; checks every pin each cycle against the timing rules.
    task automatic run_access(input bit dma, input bit w, input logic [15:0] a,
                              input logic [7:0] d, input logic [7:0] pd);
        bit   inwin, ecs;
        int   last;
        logic [3:0] exp_strb;
        logic [1:0] exp_ack;
        inwin = (a < 16'h8000) || (a >= 16'hA000 && a < 16'hC000);
        ecs   = (a >= 16'hA000 && a < 16'hC000);
        last  = inwin ? S + T + 1 : 1;
        DFromPak = pd ^ 8'($urandom_range(1, 255));
        if (dma) begin
            DmaReq = 1'b1; DmaWrite = w; DmaAddr = a; DmaWData = d;
        end else begin
            CpuReq = 1'b1; CpuWrite = w; CpuAddr = a; CpuWData = d;
        end
        if (inwin) begin
            m_addr = a;
            if (w) m_dtopak = d;
        end
        m_last_dma = dma;
        for (int k = 1; k <= last; k++) begin
            @(posedge Clk); #1;
            exp_strb = {inwin && !w && k <= S + T,
                        inwin && w && k > S && k <= S + T,
                        inwin && k > S && k <= S + T,
                        inwin && ecs};
            exp_ack  = {k == last && !dma, k == last && dma};
            checks++;
            if ({Read, Write, PakClk, CS} !== exp_strb) begin
                errors++;
                $display("FAIL strobes a=%h k=%0d got RWKC=%b want %b", a, k,
                         {Read, Write, PakClk, CS}, exp_strb);
            end
            checks++;
            if ({CpuAck, DmaAck} !== exp_ack) begin
                errors++;
                $display("FAIL acks a=%h k=%0d got cpu/dma=%b want %b", a, k,
                         {CpuAck, DmaAck}, exp_ack);
            end
            checks++;
            if (Address !== m_addr || DToPak !== m_dtopak) begin
                errors++;
                $display("FAIL bus a=%h k=%0d got addr=%h dout=%h want addr=%h dout=%h",
                         a, k, Address, DToPak, m_addr, m_dtopak);
            end
            if (k == 1) begin
                if (dma) begin DmaAddr = 16'($urandom); DmaWData = 8'($urandom); end
                else     begin CpuAddr = 16'($urandom); CpuWData = 8'($urandom); end
            end
            DFromPak = (k == S + T) ? pd : pd ^ 8'($urandom_range(1, 255));
        end
        if (!w) begin
            if (dma) m_dma_rdata = inwin ? pd : 8'hFF;
            else     m_cpu_rdata = inwin ? pd : 8'hFF;
        end
        checks++;
        if (CpuRData !== m_cpu_rdata || DmaRData !== m_dma_rdata) begin
            errors++;
            $display("FAIL rdata a=%h got cpu=%h dma=%h want cpu=%h dma=%h",
                     a, CpuRData, DmaRData, m_cpu_rdata, m_dma_rdata);
        end
        CpuReq = 1'b0;
        DmaReq = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if ({CpuAck, DmaAck, PakReset, Read, Write, PakClk, CS} !== 7'b0) begin
            errors++;
            $display("FAIL idle_after a=%h got ack/rst/strb=%b want 0000000", a,
                     {CpuAck, DmaAck, PakReset, Read, Write, PakClk, CS});
        end
    endtask

    task automatic test_reset();
        int n, spurious;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++;
        if ({PakReset, PakClk, Read, Write, CS, CpuAck, DmaAck} !== 7'b1000000 ||
            Address !== 16'h0000 || DToPak !== 8'h00 ||
            CpuRData !== 8'hFF || DmaRData !== 8'hFF) begin
            errors++;
            $display("FAIL reset_values got ctl=%b addr=%h dout=%h rd=%h/%h",
                     {PakReset, PakClk, Read, Write, CS, CpuAck, DmaAck},
                     Address, DToPak, CpuRData, DmaRData);
        end
        repeat (3) @(posedge Clk);
        #1;
        CpuReq = 1'b1; CpuWrite = 1'b0; CpuAddr = 16'h0150;
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset();
        n = 0; spurious = 0;
        while (PakReset === 1'b1 && n < 100) begin
            n++;
            if (CpuAck !== 1'b0 || DmaAck !== 1'b0) spurious++;
            @(posedge Clk); #1;
        end
        checks++;
        if (n != RH) begin
            errors++;
            $display("FAIL pakreset_len got %0d cycles want %0d", n, RH);
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL ack_during_reset got %0d acks want 0", spurious);
        end
        run_access(1'b0, 1'b0, 16'h0150, 8'h00, 8'h3C);
    endtask

    task automatic test_cpu_read();
        run_access(1'b0, 1'b0, 16'h0150, 8'h11, 8'h3C);
        checks++;
        if (CpuRData !== 8'h3C) begin
            errors++;
            $display("FAIL cpu_read_0150 got %h want 3c", CpuRData);
        end
    endtask

    task automatic test_dma_write();
        run_access(1'b1, 1'b1, 16'hA123, 8'h5A, 8'hC3);
        checks++;
        if (DToPak !== 8'h5A || Address !== 16'hA123) begin
            errors++;
            $display("FAIL dma_write_a123 got addr=%h dout=%h want a123/5a", Address, DToPak);
        end
    endtask

    task automatic test_out_of_window();
        run_access(1'b0, 1'b0, 16'hC000, 8'h00, 8'h42);
        run_access(1'b1, 1'b1, 16'h8000, 8'hAB, 8'h42);
        run_access(1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h42);
    endtask

    task automatic test_window_bounds();
        logic [15:0] b [6];
        b = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000};
        for (int i = 0; i < 6; i++)
            run_access(1'($urandom), 1'($urandom), b[i], 8'($urandom), 8'($urandom));
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(16'h0000, 16'h7FFF));
                1: a = 16'($urandom_range(16'hA000, 16'hBFFF));
                2: a = 16'($urandom_range(16'h8000, 16'h9FFF));
                default: a = 16'($urandom_range(16'hC000, 16'hFFFF));
            endcase
            run_access(1'($urandom), 1'($urandom), a, 8'($urandom), 8'($urandom));
        end
    endtask

    // Both requests held for four grants; the winner alternates starting from the
    // opposite of whoever was granted last (first burst after CPU, second after DMA).
    task automatic test_back_to_back();
        logic [15:0] ca, da;
        logic [7:0]  pd;
        bit          win, exp_ack;
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 0) run_access(1'b0, 1'b0, 16'h0300, 8'h00, 8'h5C);
            else          run_access(1'b1, 1'b0, 16'hE000, 8'h00, 8'h5C);
            ca = 16'h0200 + 16'($urandom_range(0, 255));
            da = 16'hA000 + 16'($urandom_range(0, 255));
            pd = 8'($urandom);
            DFromPak = pd;
            CpuReq = 1'b1; CpuWrite = 1'b0; CpuAddr = ca;
            DmaReq = 1'b1; DmaWrite = 1'b0; DmaAddr = da;
            win = 1'b0;
            for (int i = 0; i < 4; i++) begin
                win = !m_last_dma;
                m_last_dma = win;
                for (int k = 1; k <= ((i == 3) ? S + T + 1 : S + T + 2); k++) begin
                    @(posedge Clk); #1;
                    exp_ack = (k == S + T + 1);
                    checks++;
                    if ({CpuAck, DmaAck} !== {exp_ack && !win, exp_ack && win}) begin
                        errors++;
                        $display("FAIL b2b_ack rep=%0d i=%0d k=%0d got cpu/dma=%b want %b",
                                 rep, i, k, {CpuAck, DmaAck}, {exp_ack && !win, exp_ack && win});
                    end
                    if (exp_ack) begin
                        checks++;
                        if (Address !== (win ? da : ca) ||
                            (win ? DmaRData : CpuRData) !== pd) begin
                            errors++;
                            $display("FAIL b2b_data rep=%0d i=%0d got addr=%h rd=%h want addr=%h rd=%h",
                                     rep, i, Address, win ? DmaRData : CpuRData,
                                     win ? da : ca, pd);
                        end
                    end
                end
            end
            CpuReq = 1'b0;
            DmaReq = 1'b0;
            m_addr = win ? da : ca;
            m_cpu_rdata = pd;
            m_dma_rdata = pd;
            @(posedge Clk); #1;
            checks++;
            if ({CpuAck, DmaAck} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_tail got cpu/dma=%b want 00", {CpuAck, DmaAck});
            end
        end
    endtask

    task automatic test_reset_midflight();
        int n, spurious;
        DFromPak = 8'h77;
        CpuReq = 1'b1; CpuWrite = 1'b0; CpuAddr = 16'h1234;
        repeat (S + 1) begin
            @(posedge Clk); #1;
        end
        checks++;
        if ({Read, PakClk} !== 2'b11) begin
            errors++;
            $display("FAIL midflight_strobe got read/clk=%b want 11", {Read, PakClk});
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({PakReset, PakClk, Read, Write, CS, CpuAck, DmaAck} !== 7'b1000000 ||
            Address !== 16'h0000) begin
            errors++;
            $display("FAIL midflight_async got ctl=%b addr=%h want 1000000/0000",
                     {PakReset, PakClk, Read, Write, CS, CpuAck, DmaAck}, Address);
        end
        CpuReq = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        n = 0; spurious = 0;
        while (PakReset === 1'b1 && n < 100) begin
            n++;
            if (CpuAck !== 1'b0 || DmaAck !== 1'b0) spurious++;
            @(posedge Clk); #1;
        end
        checks++;
        if (n != RH || spurious != 0) begin
            errors++;
            $display("FAIL midflight_rsthold got len=%0d acks=%0d want %0d/0", n, spurious, RH);
        end
        checks++;
        if (CpuRData !== 8'hFF) begin
            errors++;
            $display("FAIL midflight_rdata got %h want ff", CpuRData);
        end
        run_access(1'b0, 1'b0, 16'h1234, 8'h00, 8'h99);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_out_of_window();
        test_window_bounds();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
